// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes and receiver states.
// Also used by the parametrised transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Expected parity bit for a data XOR under the given mode.
  function automatic logic par_bit(input int mode, input logic x);
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop rx synchronizer with a one-clk delayed copy.
// fall pulses for one clk on a synchronized 1-to-0 transition.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic sync;
  logic dly;

  // Line idles high, so all stages come out of reset at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      dly  <= 1'b1;
    end else begin
      meta <= rx;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign rx_s = sync;
  assign fall = dly & ~sync;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, midpoint sampling,
// parity and frame error reporting with a one-clk valid strobe.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 os_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST = 4'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  rx_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bit_idx, bit_idx_n;
  logic stop_idx, stop_idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic par_acc, par_acc_n;
  logic perr_i, perr_n;
  logic ferr_i, ferr_n;
  logic done;
  logic tick_mid;

  assign tick_mid = os_tick && (cnt == CNT_LAST);
  assign busy = (state != IDLE);

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      perr_i   <= 1'b0;
      ferr_i   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      stop_idx <= stop_idx_n;
      shreg    <= shreg_n;
      par_acc  <= par_acc_n;
      perr_i   <= perr_n;
      ferr_i   <= ferr_n;
    end
  end

  // Next-state, sampling and error accumulation.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    par_acc_n  = par_acc;
    perr_n     = perr_i;
    ferr_n     = ferr_i;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (os_tick) begin
          if (cnt == CNT_HALF) begin
            cnt_n = '0;
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n   = DATA;
              bit_idx_n = '0;
              par_acc_n = 1'b0;
              perr_n    = 1'b0;
              ferr_n    = 1'b0;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_mid) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[DATA_BITS-1:1]};
          par_acc_n = par_acc ^ rx_s;
          bit_idx_n = bit_idx + 4'd1;
          if (bit_idx == BIT_LAST) begin
            stop_idx_n = 1'b0;
            state_n = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end
        end else if (os_tick) begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (tick_mid) begin
          cnt_n      = '0;
          stop_idx_n = 1'b0;
          state_n    = STOP;
          if (rx_s != par_bit(PARITY_MODE, par_acc)) begin
            perr_n = 1'b1;
          end
        end else if (os_tick) begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (tick_mid) begin
          cnt_n = '0;
          if (!rx_s) begin
            ferr_n = 1'b1;
          end
          if (stop_idx == STOP_LAST) begin
            state_n = IDLE;
            done    = 1'b1;
          end else begin
            stop_idx_n = stop_idx + 1'b1;
          end
        end else if (os_tick) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Publish the word and flags one clk after the last stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid <= done;
      if (done) begin
        data       <= shreg_n;
        parity_err <= perr_n;
        frame_err  <= ferr_n;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver for the serial drive layer; successor to the fixed 8-bit, 16x receiver.
- Configurable oversampling ratio, data width, parity mode and stop-bit count.
- Qualifies start bits and samples each bit at its midpoint.
- Reports parity and frame errors alongside each received word, with a one-cycle valid strobe.
- Sits between the pad-side rx line and the CRC/packet logic; runs on the system clk with an oversample-rate tick enable.

Parameters:
OVERSAMPLE, 16, os_tick pulses per bit; even, >= 4
DATA_BITS, 8, data bits per frame (5..9), sent LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
os_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate
rx  in  1  asynchronous serial input, idle high
data  out  DATA_BITS  last received word
valid  out  1  one-clk strobe; data and error flags are valid in this cycle
parity_err  out  1  parity mismatch on the last frame (0 when PARITY_MODE = 0)
frame_err  out  1  a sampled stop bit was 0 on the last frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n = 0, asynchronous, active-low; clock clk):
  - data = 0, valid = 0, parity_err = 0, frame_err = 0, busy = 0.
  - FSM returns to IDLE; synchronizer flops reset to 1.
- Input conditioning:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - rx_d is rx_s delayed by one clk.
  - A start edge is rx_d = 1 and rx_s = 0.
- Counting:
  - cnt is $clog2(OVERSAMPLE) bits wide and advances only on os_tick.
  - All FSM transitions and samples below occur on os_tick cycles unless stated otherwise.
- IDLE:
  - A start edge (clk-rate detection, independent of os_tick) moves to START with cnt = 0.
  - A line held low never retriggers; a new frame needs a 1-to-0 transition.
- START:
  - At cnt = OVERSAMPLE/2 - 1, sample rx_s.
  - rx_s = 1: false start; go to IDLE with no valid and no flags changed.
  - rx_s = 0: cnt = 0, bit index = 0, go to DATA.
- DATA:
  - At each cnt = OVERSAMPLE - 1 (the midpoint, because of the half-bit offset from START), shift rx_s into the shift register LSB first, clear cnt, and increment bit index.
  - Accumulate a running XOR of the data bits.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, otherwise to STOP.
- PARITY:
  - Sample at cnt = OVERSAMPLE - 1.
  - Expected bit = XOR(data) for even, ~XOR(data) for odd.
  - On mismatch, set the internal parity error bit; then go to STOP.
- STOP:
  - Sample STOP_BITS bits, each at cnt = OVERSAMPLE - 1.
  - Any sampled 0 sets the internal frame error bit.
  - After the last stop sample, go directly to IDLE (mid stop bit) so the next start edge can be caught.
- Output update:
  - On the clk after the last stop sample: data <= shift register, parity_err and frame_err <= internal bits, valid = 1 for exactly one clk.
  - data and the flags hold until the next frame completes.
- valid is also asserted on frame error; the consumer decides whether to drop the word.
- Break condition (rx held low for a full frame): data = 0, frame_err = 1 (and parity_err per mode), then wait in IDLE until rx rises and falls again.
- os_tick is ignored in IDLE. rx edges outside IDLE are ignored.
- Reset mid-frame discards the partial frame; no valid is generated.
- Latency: valid asserts 1 clk after the os_tick that samples the last stop bit.

Decomposition:
- Package uart_pkg holds:
  - Parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2.
  - The FSM state encoding IDLE, START, DATA, PARITY, STOP.
  - Shared by the future parametrised transmitter.
- Sub-module uart_rx_sync: the 2-flop synchronizer plus falling-edge detect.
  - Outputs rx_s and fall.
  - Reused by the transmitter-side loopback checker.

Test Plan:
- Defaults (16x, 8N1): send 0xA5 -> exactly one valid pulse, data = 0xA5, parity_err = 0, frame_err = 0, busy low within 1 clk after valid.
- PARITY_MODE = 1: send 0x37 with parity bit 1 -> parity_err = 0. Repeat with parity bit 0 -> parity_err = 1, data = 0x37.
- Drive rx low for 4 os_ticks, then high -> no valid, busy returns to 0, next frame 0x5A is received correctly.
- Send 0x3C with a stop bit of 0 -> valid, data = 0x3C, frame_err = 1. Follow with a good 0x11 -> frame_err = 0.
- STOP_BITS = 2, DATA_BITS = 7: two back-to-back frames 0x7F and 0x00 with no idle gap -> two valid pulses, data in order.
- Assert rst_n low during data bit 4 of a frame -> all outputs 0 immediately; no valid from that frame; the next full frame is received correctly.
